// File: rtl/ifid_hazard_pkg.sv
// ---------------------------------------------------------------------------
// ifid_hazard_pkg
// Shared constants for the IF/ID pipeline register and its load-use hazard
// detector: data and register-index widths, instruction field positions,
// the NOP encoding, the opcode/funct values, and a sign-extension helper.
// ---------------------------------------------------------------------------
package ifid_hazard_pkg;

    localparam int DATA_W  = 32;  // instruction / PC width
    localparam int REG_W   = 5;   // register-index width
    localparam int OP_W    = 6;   // opcode / funct width
    localparam int IMM_W   = 16;  // I-type immediate width

    // Field LSB positions inside an instruction word
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

    // A flushed slot is an all-zero word (sll $0,$0,0)
    localparam logic [DATA_W-1:0] NOP = '0;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // Funct codes for R-type
    localparam logic [OP_W-1:0] FN_SLL   = 6'h00;
    localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
    localparam logic [OP_W-1:0] FN_AND   = 6'h24;
    localparam logic [OP_W-1:0] FN_OR    = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

    function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/ifid_hazard_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector. A hazard exists when the
// instruction in ID is live and reads (as Rs or Rt) the non-zero register a
// load currently in EX is about to write.
// Ports:
//   valid        in  : IF/ID slot holds a live instruction
//   idex_memread in  : instruction in ID/EX is a load
//   idex_rt      in  : destination (Rt) of the instruction in ID/EX
//   id_rs, id_rt in  : source fields of the instruction in ID
//   hazard       out : load-use hazard detected
//   pc_write     out : PC update enable (low while stalling)
//   ctrl_bubble  out : zero the controls entering ID/EX
// ---------------------------------------------------------------------------
module hazard_detect
    import ifid_hazard_pkg::*;
(
    input  logic             valid,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard,
    output logic             pc_write,
    output logic             ctrl_bubble
);

    // $0 is never a real destination, so a load into it cannot cause a stall.
    assign hazard = valid & idex_memread & (idex_rt != '0) &
                    ((idex_rt == id_rs) | (idex_rt == id_rt));

    assign pc_write    = ~hazard;
    assign ctrl_bubble = hazard;

endmodule

// File: rtl/ifid_hazard.sv
// ---------------------------------------------------------------------------
// ifid_hazard
// IF/ID pipeline register with load-use stall, branch flush, combinational
// decode of the held instruction, and optional stall/flush event counters.
//
// Optional feature: define IFID_PERF_CNT_EN to build saturating StallCount
// and FlushCount counters; otherwise both ports read constant 0 and no
// counter flops exist.
//
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low reset
//   PCplus4, Instr          : IF-stage PC+4 and fetched instruction
//   BranchTaken             : branch taken in ID, flushes the IF/ID slot
//   IDEX_MemRead, IDEX_RegRt: load flag and Rt of the instruction in ID/EX
//   PCWrite, CtrlBubble     : stall controls (combinational)
//   PCplus4reg, Instrreg    : registered IF/ID contents
//   Validreg                : Instrreg holds a live instruction
//   RegRs/RegRt/RegRd, IDShamt, Opcode, Funct, imm_value : decode fields
//   StallCount, FlushCount  : event counters
// ---------------------------------------------------------------------------
module ifid_hazard
    import ifid_hazard_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] PCplus4,
    input  logic [DATA_W-1:0] Instr,
    input  logic              BranchTaken,
    input  logic              IDEX_MemRead,
    input  logic [REG_W-1:0]  IDEX_RegRt,
    output logic              PCWrite,
    output logic              CtrlBubble,
    output logic [DATA_W-1:0] PCplus4reg,
    output logic [DATA_W-1:0] Instrreg,
    output logic              Validreg,
    output logic [REG_W-1:0]  RegRs,
    output logic [REG_W-1:0]  RegRt,
    output logic [REG_W-1:0]  RegRd,
    output logic [REG_W-1:0]  IDShamt,
    output logic [OP_W-1:0]   Opcode,
    output logic [OP_W-1:0]   Funct,
    output logic [DATA_W-1:0] imm_value,
    output logic [DATA_W-1:0] StallCount,
    output logic [DATA_W-1:0] FlushCount
);

    logic hazard;

    // ---------------- decode of the held instruction ----------------
    assign Opcode    = Instrreg[OP_LSB    +: OP_W];
    assign RegRs     = Instrreg[RS_LSB    +: REG_W];
    assign RegRt     = Instrreg[RT_LSB    +: REG_W];
    assign RegRd     = Instrreg[RD_LSB    +: REG_W];
    assign IDShamt   = Instrreg[SHAMT_LSB +: REG_W];
    assign Funct     = Instrreg[FUNCT_LSB +: OP_W];
    assign imm_value = sign_extend_imm(Instrreg[IMM_LSB +: IMM_W]);

    // ---------------- hazard detection ----------------
    hazard_detect u_hazard_detect (
        .valid        (Validreg),
        .idex_memread (IDEX_MemRead),
        .idex_rt      (IDEX_RegRt),
        .id_rs        (RegRs),
        .id_rt        (RegRt),
        .hazard       (hazard),
        .pc_write     (PCWrite),
        .ctrl_bubble  (CtrlBubble)
    );

    // ---------------- IF/ID register ----------------
    // The stall needs no timer: the bubble it injects clears IDEX_MemRead on
    // the next cycle, which removes the hazard by itself. A stall also beats
    // a simultaneous branch, which re-resolves once the bubble has passed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            PCplus4reg <= '0;
            Instrreg   <= NOP;
            Validreg   <= 1'b0;
        end else if (!hazard) begin
            // NOTE: non-blocking assignments for all flop state, so every
            // register samples pre-edge values regardless of statement order.
            // Leaving the hazard case without an assignment is a clock-enable
            // hold on a flop, not a latch, because this block is edge-triggered.
            PCplus4reg <= PCplus4;
            if (BranchTaken) begin
                Instrreg <= NOP;
                Validreg <= 1'b0;
            end else begin
                Instrreg <= Instr;
                Validreg <= 1'b1;
            end
        end
    end

    // ---------------- event counters ----------------
`ifdef IFID_PERF_CNT_EN
    logic              flush;
    logic [DATA_W-1:0] stall_count;
    logic [DATA_W-1:0] flush_count;

    assign flush = BranchTaken & ~hazard;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (hazard && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

    assign StallCount = stall_count;
    assign FlushCount = flush_count;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
